// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-FIFO entry layout.
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int RX_ENTRY_W     = 10;
    localparam int RX_TIMEOUT_OS  = 640;

    typedef struct packed {
        logic                      frame_err;
        logic                      parity_err;
        logic [UART_DATA_BITS-1:0] data;
    } rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Character handshake between the UART receiver, the RX FIFO and the host side.
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [UART_DATA_BITS-1:0] in_data;
    logic                      in_parity_err;
    logic                      in_frame_err;
    logic                      out_valid;
    logic                      out_ready;
    logic [UART_DATA_BITS-1:0] out_data;
    logic                      out_parity_err;
    logic                      out_frame_err;

    // slave is the FIFO; master drives characters in and pops them out
    modport slave (
        input  in_valid, in_data, in_parity_err, in_frame_err, out_ready,
        output in_ready, out_valid, out_data, out_parity_err, out_frame_err
    );
    modport master (
        output in_valid, in_data, in_parity_err, in_frame_err, out_ready,
        input  in_ready, out_valid, out_data, out_parity_err, out_frame_err
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x W register array: synchronous write, asynchronous read.
module sync_fifo_mem #(
    parameter  int DEPTH = 16,
    parameter  int W     = 10,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // Cleared on reset so the head reads zero and no stale character survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer with occupancy, overrun and idle-timeout status.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int THRESH     = 8,
    parameter  int TIMEOUT_OS = RX_TIMEOUT_OS,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          oversample_tick,
    uart_rx_fifo_if.slave rx,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          overrun,
    input  logic          overrun_clr,
    output logic          rx_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_OS + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [TW-1:0] TO_C     = TW'(TIMEOUT_OS);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] idle_cnt;
    logic          ready_q;
    logic          push, pop, wr_en, drop;
    rx_entry_t     wr_entry, head;

    assign push  = rx.in_valid && ready_q;
    assign pop   = !empty && rx.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign wr_entry = '{frame_err: rx.in_frame_err, parity_err: rx.in_parity_err, data: rx.in_data};

    sync_fifo_mem #(.DEPTH(DEPTH), .W(RX_ENTRY_W)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            ready_q <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)             overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
            // Any traffic, or nothing to report, restarts the idle measurement.
            if (push || pop || empty)
                idle_cnt <= '0;
            else if (oversample_tick && idle_cnt != TO_C)
                idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= THRESH_C);
    assign rx_timeout  = (idle_cnt == TO_C) && !empty;

    assign rx.in_ready       = ready_q;
    assign rx.out_valid      = !empty;
    assign rx.out_data       = head.data;
    assign rx.out_parity_err = head.parity_err;
    assign rx.out_frame_err  = head.frame_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed-vector bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       oversample_tick;
    logic       overrun_clr;
    logic [4:0] count;
    logic       empty, full, almost_full, overrun, rx_timeout;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] q[$];

    uart_rx_fifo_if bus();

    uart_rx_fifo dut (
        .clk             (clk),
        .reset           (reset),
        .oversample_tick (oversample_tick),
        .rx              (bus),
        .count           (count),
        .empty           (empty),
        .full            (full),
        .almost_full     (almost_full),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr),
        .rx_timeout      (rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [7:0] d, input logic p, input logic f);
        bus.in_valid      = v;
        bus.in_data       = d;
        bus.in_parity_err = p;
        bus.in_frame_err  = f;
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic f);
        drive_in(1'b1, d, p, f);
        cyc();
        drive_in(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] d);
        drive_in(1'b1, d, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        cyc();
        drive_in(1'b0, 8'h00, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        oversample_tick = 1'b0;
        overrun_clr = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b0, 8'h00, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", {bus.out_frame_err, bus.out_parity_err, bus.out_data}, 10'h000);
        chk("rst_count", count, 5'd0);
        chk("rst_flags", {empty, full, almost_full, overrun, rx_timeout}, 5'b10000);
        reset = 1'b0;
        cyc();
        chk("in_ready_after_rst", bus.in_ready, 1'b1);

        // single character, one-cycle latency
        push(8'h41, 1'b0, 1'b0);
        chk("t1_valid", bus.out_valid, 1'b1);
        chk("t1_data", bus.out_data, 8'h41);
        chk("t1_count", count, 5'd1);
        chk("t1_empty", empty, 1'b0);
        pop();
        chk("t1_empty_after_pop", {empty, bus.out_valid}, 2'b10);

        // per-entry error flags
        push(8'h55, 1'b1, 1'b0);
        push(8'hAA, 1'b0, 1'b1);
        chk("t2_head0", {bus.out_frame_err, bus.out_parity_err, bus.out_data}, 10'h155);
        pop();
        chk("t2_head1", {bus.out_frame_err, bus.out_parity_err, bus.out_data}, 10'h2AA);
        pop();
        chk("t2_empty", empty, 1'b1);

        // fill, almost_full threshold, overrun
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 1'b0, 1'b0);
            chk($sformatf("t3_af_%0d", i + 1), almost_full, (i + 1) >= 8);
        end
        chk("t3_full", {full, count}, {1'b1, 5'd16});
        push(8'hFF, 1'b0, 1'b0);
        chk("t3_overrun", overrun, 1'b1);
        chk("t3_count_drop", count, 5'd16);
        chk("t3_head_drop", bus.out_data, 8'h00);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t3_overrun_clr", overrun, 1'b0);
        // set beats clear in the same cycle
        overrun_clr = 1'b1;
        push(8'hEE, 1'b0, 1'b0);
        overrun_clr = 1'b0;
        chk("t3_set_wins", overrun, 1'b1);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t3_clr2", overrun, 1'b0);

        // push and pop together while full
        push_pop(8'h77);
        chk("t4_count_full_pp", count, 5'd16);
        chk("t4_no_overrun", overrun, 1'b0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t4_drain_%0d", i), bus.out_data, 8'(i));
            pop();
        end
        chk("t4_last", bus.out_data, 8'h77);
        pop();
        chk("t4_empty", {empty, count}, {1'b1, 5'd0});

        // push and pop together while empty: the pop is ignored
        push_pop(8'h80);
        chk("t4_empty_pp_count", count, 5'd1);
        chk("t4_empty_pp_head", bus.out_data, 8'h80);
        q.push_back(8'h80);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("t4_wrap_%0d", i), bus.out_data, q[0]);
            push_pop(8'(8'h81 + i));
            void'(q.pop_front());
            q.push_back(8'(8'h81 + i));
        end
        chk("t4_wrap_count", count, 5'd1);
        chk("t4_wrap_head", bus.out_data, q[0]);

        // idle timeout with one entry held, a tick every other cycle
        for (int i = 0; i < 639; i++) begin
            oversample_tick = 1'b1;
            cyc();
            oversample_tick = 1'b0;
            cyc();
        end
        chk("t5_before_640", rx_timeout, 1'b0);
        oversample_tick = 1'b1;
        cyc();
        oversample_tick = 1'b0;
        chk("t5_at_640", rx_timeout, 1'b1);
        pop();
        chk("t5_pop_clears", {rx_timeout, empty}, 2'b01);
        oversample_tick = 1'b1;
        for (int i = 0; i < 1000; i++) cyc();
        oversample_tick = 1'b0;
        chk("t5_empty_no_to", rx_timeout, 1'b0);

        // reset mid-operation with overrun set and 5 entries left
        for (int i = 0; i < 17; i++) push(8'(8'h20 + i), 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) pop();
        chk("t6_pre_count", count, 5'd5);
        chk("t6_pre_overrun", overrun, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_count", count, 5'd0);
        chk("t6_flags", {empty, overrun, bus.out_valid, bus.in_ready}, 4'b1000);
        chk("t6_head", {bus.out_frame_err, bus.out_parity_err, bus.out_data}, 10'h000);
        cyc();
        push(8'h3C, 1'b0, 1'b1);
        chk("t6_after", {bus.out_frame_err, bus.out_parity_err, bus.out_data}, 10'h23C);
        chk("t6_after_count", count, 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer that sits directly downstream of the UART receiver and upstream of the host/register interface. It accepts each received character with its parity and framing error flags and stores it in a first-word-fall-through FIFO. It also provides occupancy and threshold status, a sticky overrun flag when a character arrives while the FIFO is full, and a character-timeout indication measured in 16x oversample ticks.

## Interface
Parameters:
- DEPTH, 16: number of entries; power of two, at least 4.
- THRESH, 8: almost-full level, in the range 1..DEPTH.
- TIMEOUT_OS, 640: idle oversample ticks before `rx_timeout` (4 characters × 10 bits × 16).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- oversample_tick  in  1  16x baud tick; the same tick that drives the receiver.
- in_valid  in  1  character available from the receiver.
- in_ready  out  1  accept; high whenever not in reset.
- in_data  in  8  received character.
- in_parity_err  in  1  parity error flag for `in_data`.
- in_frame_err  in  1  framing error flag for `in_data`.
- out_valid  out  1  head entry valid; equals `!empty`.
- out_ready  in  1  consumer pops the head entry.
- out_data  out  8  head character.
- out_parity_err  out  1  head entry's parity flag.
- out_frame_err  out  1  head entry's framing flag.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= THRESH.
- overrun  out  1  sticky; a character was dropped.
- overrun_clr  in  1  clears `overrun`.
- rx_timeout  out  1  FIFO is non-empty and has been idle for TIMEOUT_OS ticks.

## Operation
- Each entry is 10 bits: {frame_err, parity_err, data}.
- A push is `in_valid && in_ready`. A pop is `out_valid && out_ready`.
- The FIFO never back-pressures the receiver. `in_ready` is 1 in every cycle after reset.
- Push when not full: write the entry at `wr_ptr`, then increment `wr_ptr`.
- Push when full with no pop in the same cycle: drop the character, leave pointers unchanged, set `overrun`.
- Push and pop in the same cycle when full: both take effect and `count` stays at DEPTH. No overrun.
- Push and pop in the same cycle when empty: the push takes effect, the pop is ignored because `out_valid` is 0, and `count` becomes 1.
- Pop when empty is ignored. Pointers and count do not underflow.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` is tracked separately: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- `overrun_clr` clears `overrun`. If a set and a clear happen in the same cycle, the set wins.
- Timeout counter:
  - Clears to 0 on any push, on any pop, or while the FIFO is empty.
  - Otherwise increments on each `oversample_tick`, saturating at TIMEOUT_OS.
  - `rx_timeout` = (counter == TIMEOUT_OS) && !empty.
- Error flags are stored per entry and never merged; the consumer sees each flag only with its own character.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 from the first cycle after it; `out_valid`=0, `out_data`/`out_parity_err`/`out_frame_err`=0, `count`=0, `empty`=1, `full`=0, `almost_full`=0, `overrun`=0, `rx_timeout`=0; both pointers and the timeout counter are 0.
- Push at edge N: `out_valid`, `count`, `full` and `almost_full` reflect the new state after edge N, i.e. in cycle N+1. Latency from empty to out_valid is one cycle.
- Head outputs are combinational reads of `mem[rd_ptr]` and stay stable while `out_valid && !out_ready`.
- Pop at edge N: the next entry (or `out_valid`=0) is presented in cycle N+1.
- `overrun` rises in the cycle after the dropped push.
- `rx_timeout` rises in the cycle after the TIMEOUT_OS-th qualifying tick. It falls in the cycle after a push or pop.
- Reset asserted mid-operation discards all contents. No partial state survives.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_BITS`=8.
  - Entry struct/width constant `RX_ENTRY_W`=10.
  - Default `RX_TIMEOUT_OS`=640.
- Sub-module `sync_fifo_mem`: a DEPTH×RX_ENTRY_W register array with a synchronous write port and an asynchronous read port. Control logic, counters and flags stay in `uart_rx_fifo`.

## Test plan
- After reset: push 0x41 (no errors) → next cycle `out_valid`=1, `out_data`=0x41, `count`=1, `empty`=0. Pop it → `empty`=1.
- Push 0x55 with `in_parity_err`=1, then 0xAA with `in_frame_err`=1 → read back in order with flags {0x55, p=1, f=0} and {0xAA, p=0, f=1}.
- Fill 16 entries 0x00..0x0F → `full`=1, `almost_full` first set at count 8. Push 0xFF with no pop → `overrun`=1, `count`=16, head still 0x00. Pulse `overrun_clr` → `overrun`=0.
- While full, push 0x77 and pop in the same cycle → `count`=16, `overrun` stays 0. After draining, 0x77 is the last entry read. Pointers wrap correctly over 40 push/pop cycles.
- One entry held with no activity → `rx_timeout` rises after exactly 640 ticks. A pop drops it the next cycle. With the FIFO empty, 1000 ticks → `rx_timeout` stays 0.
- Assert reset with 5 entries stored → next cycle `count`=0, `empty`=1, `overrun`=0, `out_valid`=0.
